// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between the datapath fetch port and
// the memory controller, with zero-latency hits and saturating hit/miss counters.
module icache_direct #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dp_imemREN,
  input  logic [31:0]      dp_imemaddr,
  output logic             dp_ihit,
  output logic [31:0]      dp_imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [29:0]       miss_addr_q;
  logic              iren_q;
  logic [31:0]       iaddr_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              unused_byte_off;

  assign lk_idx          = dp_imemaddr[IDX_W+1:2];
  assign lk_tag          = dp_imemaddr[31:IDX_W+2];
  assign fill_idx        = miss_addr_q[IDX_W-1:0];
  assign fill_tag        = miss_addr_q[29:IDX_W];
  assign unused_byte_off = ^dp_imemaddr[1:0];

  always_comb begin
    hit = 1'b0;
    if (state_q == IDLE && dp_imemREN && valid_q[lk_idx] && tag_q[lk_idx] == lk_tag) begin
      hit = 1'b1;
    end
  end

  assign dp_ihit     = hit;
  assign dp_imemload = hit ? data_q[lk_idx] : '0;
  assign iREN        = iren_q;
  assign iaddr       = iaddr_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      iren_q      <= 1'b0;
      iaddr_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int unsigned i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (hit && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (dp_imemREN && !hit) begin
            state_q     <= MISS;
            miss_addr_q <= dp_imemaddr[31:2];
            iren_q      <= 1'b1;
            iaddr_q     <= {dp_imemaddr[31:2], 2'b00};
            if (miss_cnt_q != '1) begin
              miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
          end
        end
        MISS: begin
          // Fill always targets the latched address; datapath redirects are ignored here.
          if (!iwait) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= iload;
            state_q           <= IDLE;
            iren_q            <= 1'b0;
            iaddr_q           <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios then random traffic,
// compared against a line-residency model of the cache.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST, ren, iwait;
  logic [31:0] addr;
  logic        ihit, iren, ihit4, iren4;
  logic [31:0] load, iaddr, iload, load4, iaddr4, iload4;
  logic [31:0] hc, mc;
  logic [3:0]  hc4, mc4;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memw(input logic [29:0] w);
    if (w == 30'd0) return 32'h8C010004;
    return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  assign iload  = iwait ? 32'hDEADBEEF : memw(iaddr[31:2]);
  assign iload4 = iwait ? 32'hDEADBEEF : memw(iaddr4[31:2]);

  icache_direct #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .dp_imemREN(ren), .dp_imemaddr(addr),
    .dp_ihit(ihit), .dp_imemload(load), .iREN(iren), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hc), .miss_count(mc)
  );

  icache_direct #(.SETS(16), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .dp_imemREN(ren), .dp_imemaddr(addr),
    .dp_ihit(ihit4), .dp_imemload(load4), .iREN(iren4), .iaddr(iaddr4),
    .iwait(iwait), .iload(iload4), .hit_count(hc4), .miss_count(mc4)
  );

  // Reference model: which word address each frame holds, and whether a fetch is pending.
  bit          m_val  [16];
  logic [29:0] m_line [16];
  bit          m_miss;
  logic [29:0] m_addr;
  int unsigned m_hc, m_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat4(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    foreach (m_val[i]) m_val[i] = 1'b0;
    m_miss = 1'b0;
    m_addr = '0;
    m_hc   = 0;
    m_mc   = 0;
  endtask

  task automatic tick(input bit r, input bit re, input logic [31:0] a, input bit w);
    bit          e_hit;
    logic [31:0] e_load, e_iaddr;
    int unsigned idx;
    RST = r; ren = re; addr = a; iwait = w;
    @(negedge CLK);
    idx = a[5:2];
    if (!m_miss) begin
      e_hit   = re && m_val[idx] && (m_line[idx] == a[31:2]);
      e_load  = e_hit ? memw(a[31:2]) : 32'h0;
      e_iaddr = 32'h0;
    end else begin
      e_hit   = 1'b0;
      e_load  = 32'h0;
      e_iaddr = {m_addr, 2'b00};
    end
    chk("ihit",  {31'b0, ihit}, {31'b0, e_hit});
    chk("load",  load, e_load);
    chk("iREN",  {31'b0, iren}, {31'b0, m_miss});
    chk("iaddr", iaddr, e_iaddr);
    chk("hits",  hc, m_hc);
    chk("misses", mc, m_mc);
    chk("ihit4", {31'b0, ihit4}, {31'b0, e_hit});
    chk("hits4",  {28'b0, hc4}, sat4(m_hc));
    chk("misses4", {28'b0, mc4}, sat4(m_mc));
    if (r) begin
      model_reset();
    end else if (!m_miss) begin
      if (e_hit) m_hc++;
      else if (re) begin
        m_mc++;
        m_miss = 1'b1;
        m_addr = a[31:2];
      end
    end else if (!w) begin
      m_val[m_addr[3:0]]  = 1'b1;
      m_line[m_addr[3:0]] = m_addr;
      m_miss = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ren = 1'b0; addr = '0; iwait = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    model_reset();
    tick(1, 0, 32'h0, 1);

    // Cold miss on 0x0 with three wait cycles, then zero-latency hit
    tick(0, 1, 32'h0, 1);
    repeat (3) tick(0, 1, 32'h0, 1);
    tick(0, 1, 32'h0, 0);
    chk("tp1_load_pre", load, 32'h8C010004);
    tick(0, 1, 32'h0, 0);
    chk("tp1_mc", mc, 32'd1);
    chk("tp1_hc", hc, 32'd1);

    // Same word, aligned and misaligned
    tick(0, 1, 32'h0, 0);
    tick(0, 1, 32'h2, 0);
    chk("tp2_hc", hc, 32'd3);

    // Conflict on index 0
    tick(0, 1, 32'h40, 0);
    chk("tp3_iaddr", iaddr, 32'h40);
    tick(0, 1, 32'h40, 0);
    tick(0, 1, 32'h40, 0);
    tick(0, 1, 32'h0, 0);
    tick(0, 1, 32'h0, 0);
    chk("tp3_mc", mc, 32'd3);

    // Redirect while a fill is outstanding
    tick(0, 1, 32'h10, 1);
    tick(0, 1, 32'h100, 1);
    tick(0, 1, 32'h100, 1);
    chk("tp4_iaddr_held", iaddr, 32'h10);
    tick(0, 1, 32'h100, 0);
    tick(0, 1, 32'h100, 1);
    chk("tp4_new_iaddr", iaddr, 32'h100);
    tick(0, 1, 32'h100, 0);
    tick(0, 1, 32'h10, 0);

    // Reset in the middle of a miss
    tick(0, 1, 32'h20, 1);
    tick(1, 1, 32'h20, 1);
    chk("tp5_iren", {31'b0, iren}, 32'd0);
    chk("tp5_hc", hc, 32'd0);
    chk("tp5_mc", mc, 32'd0);
    tick(0, 1, 32'h20, 0);
    tick(0, 1, 32'h20, 0);
    tick(0, 1, 32'h20, 0);

    // Random traffic over a small address pool to mix hits, conflicts and saturation
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), ra, $urandom_range(0, 1) == 1);
    end
    repeat (20) tick(0, 1, 32'h0, 0);
    chk("sat_hc4", {28'b0, hc4}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache sitting directly downstream of the pipelined datapath's instruction-fetch port.
- Consumes the datapath's imemREN/imemaddr and returns ihit/imemload.
- On a miss, fetches one word from the memory controller through an iREN/iaddr/iwait/iload handshake, then fills the frame.
- Exposes saturating hit and miss counters for performance analysis.

Parameters:
SETS, 16, number of frames (power of two); index width IDX_W = log2(SETS).
CNT_W, 32, width of the hit and miss performance counters.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
dp_imemREN  input  1  datapath requests an instruction read this cycle.
dp_imemaddr  input  32  byte address of the requested instruction.
dp_ihit  output  1  requested word is valid on dp_imemload this cycle.
dp_imemload  output  32  instruction word.
iREN  output  1  read request to the memory controller.
iaddr  output  32  word-aligned address of the outstanding miss.
iwait  input  1  memory busy; data is not yet valid while high.
iload  input  32  memory read data; valid in the cycle iwait is low with iREN high.
hit_count  output  CNT_W  number of hit cycles.
miss_count  output  CNT_W  number of miss transactions started.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Address split:
  - [1:0] is the byte offset and is ignored.
  - [IDX_W+1:2] is the index.
  - [31:IDX_W+2] is the tag.
- Frame storage: per frame, one valid bit, a tag, and a 32-bit data word.
- Reset, applied at the clock edge with RST=1, regardless of state:
  - All valid bits and all data words are cleared to 0.
  - State goes to IDLE; miss_addr is set to 0.
  - hit_count and miss_count are set to 0.
  - Outputs after reset: dp_ihit=0, dp_imemload=0, iREN=0, iaddr=0.
  - A reset during MISS abandons the request; a late iload is ignored.
- Lookup (combinational, state IDLE only):
  - hit = dp_imemREN && valid[idx] && tag[idx]==addr tag.
  - dp_ihit = hit, and dp_imemload = data[idx]. Hit latency is 0 cycles.
  - dp_imemload is 0 whenever dp_ihit=0.
- FSM, two states: IDLE and MISS.
  - IDLE, dp_imemREN=1, no hit: latch miss_addr = {dp_imemaddr[31:2],2'b00}, increment miss_count, go to MISS.
  - IDLE, dp_imemREN=0 or hit: stay in IDLE.
  - MISS: iREN=1 and iaddr=miss_addr; dp_ihit=0.
  - MISS, iwait=1: stay in MISS.
  - MISS, iwait=0: write the frame at miss_addr's index (valid=1, tag from miss_addr, data=iload), then go to IDLE.
  - There is no fill-forwarding. The refetched word hits in the cycle after the fill.
  - Miss penalty: N memory-wait cycles plus 1 completion cycle plus 1 lookup cycle.
  - In IDLE: iREN=0 and iaddr=0.
- Request change during MISS (branch or jump redirect, or dp_imemREN dropping):
  - The outstanding fill completes using the latched miss_addr.
  - The new address is looked up only after returning to IDLE.
  - The fill is never cancelled except by reset.
- Conflict replacement: a fill overwrites the frame unconditionally. There is no dirty state, since the cache is read-only.
- Counters:
  - hit_count increments on every cycle with dp_ihit=1.
  - miss_count increments on each IDLE→MISS transition.
  - Both saturate at all-ones and never wrap.
- Not supported by design: self-modifying code and coherence. The frames are invalidated only by reset.

Test Plan:
- Reset, then read 0x00000000 with memory iwait high for 3 cycles and iload=0x8C010004 → iREN high for 4 cycles with iaddr=0x0; dp_ihit=0 throughout; next cycle dp_ihit=1, dp_imemload=0x8C010004; miss_count=1, hit_count=1.
- Re-read 0x00000000, then 0x00000002 (same word, misaligned) → dp_ihit=1 with 0 latency both cycles, no iREN; hit_count=3.
- Conflict: with SETS=16, read 0x00000040 (same index 0, different tag) → miss, iaddr=0x40, frame replaced; a subsequent read of 0x0 misses again; miss_count=3.
- Redirect mid-miss: start a miss on 0x00000010, then change dp_imemaddr to 0x00000100 while iwait=1 → iaddr stays 0x10 until completion; frame 4 is filled; then a new miss starts for 0x100.
- Reset mid-miss: assert RST while in MISS with iwait=1 → next cycle iREN=0, all counters 0; a read of the same address misses again.
- Saturation: preload hit_count near max via a CNT_W=4 build and hit 20 times → hit_count holds 4'hF.
